// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
// Instruction-memory handshake between the fetch stage and instruction memory.
// Single-outstanding request/response: imem_req is level-held with a stable
// imem_addr until a cycle where imem_req && imem_rvalid (a completion).
//
// Signals:
//   imem_req    fetch stage -> memory   request valid, held until completion
//   imem_addr   fetch stage -> memory   word address, stable while imem_req=1
//   imem_rvalid memory -> fetch stage   response valid (same cycle or later)
//   imem_rdata  memory -> fetch stage   instruction word, valid with imem_rvalid
//
// Modports:
//   master - the fetch stage
//   slave  - the instruction memory
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// runs a single-outstanding request to instruction memory and applies EX
// redirects. IF_inst/IF_pc are registered and presented every cycle; the
// IF/ID register samples them unconditionally, so stalls hold them and cycles
// without a new instruction produce NOP bubbles.
//
// Optional feature (macro IF_PERF_CNT_EN): adds saturating performance
// counters perf_fetch_cnt and perf_wait_cnt. Undefined by default.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   is_stall       hazard-unit stall, holds IF outputs
//   redirect_valid one-cycle redirect from EX
//   redirect_pc    redirect target (bits [1:0] ignored)
//   imem           instruction-memory handshake (master side)
//   IF_inst        registered instruction to IF/ID
//   IF_pc          registered PC of IF_inst
//   perf_fetch_cnt instructions delivered to IF_inst (IF_PERF_CNT_EN only)
//   perf_wait_cnt  cycles with imem_req=1, imem_rvalid=0 (IF_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               is_stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  if_fetch_stage_if.master   imem,
  output logic [31:0]        IF_inst,
  output logic [31:0]        IF_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_addr;
  logic        r_req;

  logic        w_done;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;

  assign w_done   = r_req && imem.imem_rvalid;
  assign w_tgt    = {redirect_pc[31:2], 2'b00};
  assign w_pc_inc = r_pc + 32'd4;  // wraps modulo 2^32

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign IF_inst        = r_inst;
  assign IF_pc          = r_if_pc;

  // Request and address are registered alongside the state so that imem_addr
  // is glitch-free and stable for the whole request, and imem_req falls
  // asynchronously with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_INST;
      r_if_pc      <= 32'd0;
      r_buf_inst   <= NOP_INST;
      r_buf_pc     <= 32'd0;
      r_drain_addr <= 32'd0;
      r_addr       <= 32'd0;
      r_req        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          if (redirect_valid) begin
            r_pc    <= w_tgt;
            r_addr  <= w_tgt;
            r_inst  <= NOP_INST;
            r_if_pc <= 32'd0;
          end else begin
            r_addr <= r_pc;
          end
        end

        S_FETCH: begin
          if (redirect_valid) begin
            // Flush wins over stall: the redirected-away slot is a bubble.
            r_pc    <= w_tgt;
            r_inst  <= NOP_INST;
            r_if_pc <= 32'd0;
            if (w_done) begin
              r_addr <= w_tgt;
            end else begin
              // The in-flight request must still complete at its own address.
              r_drain_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (w_done) begin
            r_pc   <= w_pc_inc;
            r_addr <= w_pc_inc;
            if (is_stall) begin
              // IF/ID cannot take it yet; park it and stop requesting.
              r_buf_inst <= imem.imem_rdata;
              r_buf_pc   <= r_pc;
              r_req      <= 1'b0;
              r_state    <= S_HOLD;
            end else begin
              r_inst  <= imem.imem_rdata;
              r_if_pc <= r_pc;
            end
          end else if (!is_stall) begin
            r_inst  <= NOP_INST;
            r_if_pc <= r_pc;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_tgt;
            r_addr  <= w_tgt;
            r_inst  <= NOP_INST;
            r_if_pc <= 32'd0;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end else if (!is_stall) begin
            r_inst  <= r_buf_inst;
            r_if_pc <= r_buf_pc;
            r_addr  <= r_pc;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        S_DRAIN: begin
          if (redirect_valid) begin
            r_pc    <= w_tgt;
            r_inst  <= NOP_INST;
            r_if_pc <= 32'd0;
          end else if (!is_stall) begin
            r_inst  <= NOP_INST;
            r_if_pc <= 32'd0;
          end
          if (w_done) begin
            // Stale data is dropped; start the real fetch at the newest pc.
            r_addr  <= redirect_valid ? w_tgt : r_pc;
            r_state <= S_FETCH;
          end else begin
            r_addr <= r_drain_addr;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        w_fetch_evt;
  logic        w_wait_evt;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_wait_cnt;

  // Only instructions that actually land in IF_inst count; dropped data and
  // redirected-away buffer contents do not.
  assign w_fetch_evt = !redirect_valid && !is_stall &&
                       (((r_state == S_FETCH) && w_done) || (r_state == S_HOLD));
  assign w_wait_evt  = r_req && !imem.imem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'd0;
      r_wait_cnt  <= 32'd0;
    end else begin
      if (w_fetch_evt && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_wait_evt && (r_wait_cnt != 32'hFFFF_FFFF)) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_wait_cnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] IF_inst;
  logic [31:0] IF_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Memory model: response arrives after wait_cycles cycles of held request;
  // data is the address with bit 0 set.
  int wait_cycles = 0;
  int mem_ctr;

  if_fetch_stage_if imem_bus ();

  assign imem_bus.imem_rvalid = imem_bus.imem_req && (mem_ctr >= wait_cycles);
  assign imem_bus.imem_rdata  = imem_bus.imem_addr | 32'd1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_ctr <= 0;
    else if (imem_bus.imem_req && !imem_bus.imem_rvalid) mem_ctr <= mem_ctr + 1;
    else mem_ctr <= 0;
  end

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .is_stall       (is_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .IF_inst        (IF_inst),
    .IF_pc          (IF_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge and release it 1 time unit after an edge, so
  // the next step() is the first active edge out of reset.
  task automatic do_reset();
    rst_n          = 1'b0;
    is_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wait_cycles = 0;
    do_reset();
    checks++;
    if (IF_inst !== NOP) begin
      failures++; $display("FAIL reset_inst: got %h expected %h", IF_inst, NOP);
    end
    checks++;
    if (IF_pc !== 32'd0) begin
      failures++; $display("FAIL reset_pc: got %h expected %h", IF_pc, 32'd0);
    end
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL reset_req: got %b expected 0", imem_bus.imem_req);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    wait_cycles = 0;
    do_reset();
    step();  // IDLE -> FETCH
    checks++;
    if (IF_inst !== NOP) begin
      failures++; $display("FAIL stream_first_edge: got %h expected %h", IF_inst, NOP);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      exp_pc = 32'(4 * k);
      checks++;
      if (IF_inst !== (exp_pc | 32'd1) || IF_pc !== exp_pc) begin
        failures++;
        $display("FAIL stream_k%0d: got inst=%h pc=%h expected inst=%h pc=%h",
                 k, IF_inst, IF_pc, exp_pc | 32'd1, exp_pc);
      end
      $display("stream: IF_pc=%h IF_inst=%h", IF_pc, IF_inst);
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp_pc;
    wait_cycles = 2;
    do_reset();
    step();
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(4 * k);
      for (int b = 0; b < 2; b++) begin
        step();
        checks++;
        if (IF_inst !== NOP || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp_pc) begin
          failures++;
          $display("FAIL latency_bubble_k%0d_b%0d: got inst=%h req=%b addr=%h expected inst=%h req=1 addr=%h",
                   k, b, IF_inst, imem_bus.imem_req, imem_bus.imem_addr, NOP, exp_pc);
        end
      end
      step();
      checks++;
      if (IF_inst !== (exp_pc | 32'd1) || IF_pc !== exp_pc) begin
        failures++;
        $display("FAIL latency_inst_k%0d: got inst=%h pc=%h expected inst=%h pc=%h",
                 k, IF_inst, IF_pc, exp_pc | 32'd1, exp_pc);
      end
      $display("latency: IF_pc=%h IF_inst=%h", IF_pc, IF_inst);
    end
  endtask

  task automatic test_stall();
    wait_cycles = 0;
    do_reset();
    step();
    for (int k = 0; k < 4; k++) step();  // delivers pcs 0..0xC, pc now 0x10
    is_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (IF_inst !== 32'h0000_000D || IF_pc !== 32'h0000_000C || imem_bus.imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_c%0d: got inst=%h pc=%h req=%b expected inst=0000000d pc=0000000c req=0",
                 k, IF_inst, IF_pc, imem_bus.imem_req);
      end
    end
    is_stall = 1'b0;
    step();
    checks++;
    if (IF_inst !== 32'h0000_0011 || IF_pc !== 32'h0000_0010) begin
      failures++;
      $display("FAIL stall_release: got inst=%h pc=%h expected inst=00000011 pc=00000010", IF_inst, IF_pc);
    end
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0014) begin
      failures++;
      $display("FAIL stall_next_addr: got req=%b addr=%h expected req=1 addr=00000014",
               imem_bus.imem_req, imem_bus.imem_addr);
    end
    step();
    checks++;
    if (IF_inst !== 32'h0000_0015 || IF_pc !== 32'h0000_0014) begin
      failures++;
      $display("FAIL stall_after: got inst=%h pc=%h expected inst=00000015 pc=00000014", IF_inst, IF_pc);
    end
    $display("stall: released with IF_pc=%h IF_inst=%h", IF_pc, IF_inst);
  endtask

  task automatic test_redirect_drain();
    wait_cycles = 2;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    step();  // IDLE redirect -> FETCH at 0x20
    redirect_valid = 1'b0;
    checks++;
    if (imem_bus.imem_addr !== 32'h0000_0020 || imem_bus.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL drain_first_req: got req=%b addr=%h expected req=1 addr=00000020",
               imem_bus.imem_req, imem_bus.imem_addr);
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();  // redirect while 0x20 still outstanding -> DRAIN
    redirect_valid = 1'b0;
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0020 ||
        IF_inst !== NOP || IF_pc !== 32'd0) begin
      failures++;
      $display("FAIL drain_hold_addr: got req=%b addr=%h inst=%h pc=%h expected req=1 addr=00000020 inst=%h pc=0",
               imem_bus.imem_req, imem_bus.imem_addr, IF_inst, IF_pc, NOP);
    end
    step();  // stale response completes and is dropped
    checks++;
    if (imem_bus.imem_addr !== 32'h0000_0100 || IF_inst !== NOP || IF_pc !== 32'd0) begin
      failures++;
      $display("FAIL drain_drop: got addr=%h inst=%h pc=%h expected addr=00000100 inst=%h pc=0",
               imem_bus.imem_addr, IF_inst, IF_pc, NOP);
    end
    step();
    step();
    checks++;
    if (IF_inst !== NOP) begin
      failures++; $display("FAIL drain_wait_bubble: got %h expected %h", IF_inst, NOP);
    end
    step();
    checks++;
    if (IF_inst !== 32'h0000_0101 || IF_pc !== 32'h0000_0100) begin
      failures++;
      $display("FAIL drain_target: got inst=%h pc=%h expected inst=00000101 pc=00000100", IF_inst, IF_pc);
    end
    $display("redirect_drain: IF_pc=%h IF_inst=%h", IF_pc, IF_inst);
  endtask

  task automatic test_redirect_stall_wrap();
    wait_cycles = 0;
    do_reset();
    step();
    step();  // IF = 1 @ 0
    is_stall = 1'b1;
    step();  // 5 @ 4 buffered, HOLD
    checks++;
    if (IF_inst !== 32'h0000_0001 || imem_bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rs_hold: got inst=%h req=%b expected inst=00000001 req=0", IF_inst, imem_bus.imem_req);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    is_stall       = 1'b0;
    checks++;
    if (IF_inst !== NOP || IF_pc !== 32'd0) begin
      failures++;
      $display("FAIL rs_flush: got inst=%h pc=%h expected inst=%h pc=0", IF_inst, IF_pc, NOP);
    end
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL rs_target: got req=%b addr=%h expected req=1 addr=fffffffc",
               imem_bus.imem_req, imem_bus.imem_addr);
    end
    step();
    checks++;
    if (IF_inst !== 32'hFFFF_FFFD || IF_pc !== 32'hFFFF_FFFC || imem_bus.imem_addr !== 32'd0) begin
      failures++;
      $display("FAIL rs_wrap: got inst=%h pc=%h addr=%h expected inst=fffffffd pc=fffffffc addr=0",
               IF_inst, IF_pc, imem_bus.imem_addr);
    end
    step();
    checks++;
    if (IF_inst !== 32'h0000_0001 || IF_pc !== 32'd0) begin
      failures++;
      $display("FAIL rs_after_wrap: got inst=%h pc=%h expected inst=00000001 pc=0", IF_inst, IF_pc);
    end
    $display("redirect_stall_wrap: IF_pc=%h IF_inst=%h", IF_pc, IF_inst);
  endtask

  task automatic test_reset_mid_drain();
    wait_cycles = 2;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();  // now in DRAIN
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0 || IF_inst !== NOP || IF_pc !== 32'd0) begin
      failures++;
      $display("FAIL mid_drain_reset: got req=%b inst=%h pc=%h expected req=0 inst=%h pc=0",
               imem_bus.imem_req, IF_inst, IF_pc, NOP);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'd0) begin
      failures++;
      $display("FAIL mid_drain_restart: got req=%b addr=%h expected req=1 addr=0",
               imem_bus.imem_req, imem_bus.imem_addr);
    end
    $display("reset_mid_drain: restart addr=%h", imem_bus.imem_addr);
  endtask

  initial begin
    rst_n          = 1'b0;
    is_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_redirect_drain();
    test_redirect_stall_wrap();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
